// File: rtl/lsr_sequencer.sv
// Front-end sequencer for the LSR3 least-squares engine: gathers a sample window,
// starts the engine, waits for completion or timeout, and hands the result back.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FILL   | accepting samples into the window until DATA_SIZE are held
// S_RUN    | window frozen, lsr_start high, waiting for done or timeout
// S_RESULT | res_valid high, result held until the consumer accepts it
module lsr_sequencer #(
  parameter int DATA_SIZE = 7,
  parameter int DATA_W    = 16,
  parameter int RES_W     = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  logic [DATA_W-1:0]           s_data_i,
  input  logic [15:0]                 cfg_shift_i,
  input  logic                        cfg_slide_i,
  input  logic                        flush_i,
  output logic [DATA_SIZE*DATA_W-1:0] lsr_data_o,
  output logic [15:0]                 lsr_shift_o,
  output logic                        lsr_start_o,
  input  logic                        lsr_done_i,
  input  logic [RES_W-1:0]            lsr_result_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [RES_W-1:0]            res_data_o,
  output logic                        res_err_o,
  output logic                        busy_o
);

  localparam int CNT_W = $clog2(DATA_SIZE + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_SIZE - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_RUN    = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_W-1:0]      win_q [DATA_SIZE];
  logic [DATA_W-1:0]      win_d [DATA_SIZE];
  logic [15:0]            shift_q, shift_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [RES_W-1:0]       res_data_q, res_data_d;
  logic                   res_err_q, res_err_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_FILL;
      count_q    <= '0;
      shift_q    <= '0;
      tmr_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      for (int i = 0; i < DATA_SIZE; i++) win_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      tmr_q      <= tmr_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      for (int i = 0; i < DATA_SIZE; i++) win_q[i] <= win_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shift_d    = shift_q;
    tmr_d      = tmr_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    for (int i = 0; i < DATA_SIZE; i++) win_d[i] = win_q[i];

    if (flush_i) begin
      state_d = S_FILL;
      count_d = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (s_valid_i) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
              if (CNT_W'(i) == count_q) win_d[i] = s_data_i;
            end
            count_d = count_q + 1'b1;
            if (count_q == CNT_LAST) begin
              shift_d = cfg_shift_i;
              tmr_d   = TMR_LOAD;
              state_d = S_RUN;
            end
          end
        end
        // timer counts down from TIMEOUT-1; done is checked first so it wins a tie
        S_RUN: begin
          if (lsr_done_i) begin
            res_data_d = lsr_result_i;
            res_err_d  = 1'b0;
            state_d    = S_RESULT;
          end else if (tmr_q == '0) begin
            res_data_d = '0;
            res_err_d  = 1'b1;
            state_d    = S_RESULT;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready_i) begin
            if (cfg_slide_i) begin
              for (int i = 0; i < DATA_SIZE - 1; i++) win_d[i] = win_q[i+1];
              count_d = CNT_LAST;
            end else begin
              count_d = '0;
            end
            state_d = S_FILL;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  for (genvar g = 0; g < DATA_SIZE; g++) begin : g_pack
    assign lsr_data_o[g*DATA_W +: DATA_W] = win_q[g];
  end

  assign s_ready_o   = (state_q == S_FILL);
  assign lsr_start_o = (state_q == S_RUN);
  assign res_valid_o = (state_q == S_RESULT);
  assign busy_o      = (state_q != S_FILL);
  assign lsr_shift_o = shift_q;
  assign res_data_o  = res_data_q;
  assign res_err_o   = res_err_q;

endmodule

// File: tb/tb_lsr_sequencer.sv
// Bench for lsr_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a window/phase model of the sequencer's behaviour.
module tb_lsr_sequencer;

  localparam int DS = 7;
  localparam int DW = 16;
  localparam int RW = 32;
  localparam int TO = 16;
  localparam int PH_FILL = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_RES  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [DW-1:0] s_data = '0;
  logic [15:0] cfg_shift = '0;
  logic cfg_slide = 1'b0;
  logic flush = 1'b0;
  logic [DS*DW-1:0] lsr_data;
  logic [15:0] lsr_shift;
  logic lsr_start;
  logic lsr_done = 1'b0;
  logic [RW-1:0] lsr_result = '0;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [RW-1:0] res_data;
  logic res_err;
  logic busy;

  always #5 clk = ~clk;

  lsr_sequencer #(.DATA_SIZE(DS), .DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .cfg_shift_i(cfg_shift), .cfg_slide_i(cfg_slide),
    .flush_i(flush), .lsr_data_o(lsr_data), .lsr_shift_o(lsr_shift),
    .lsr_start_o(lsr_start), .lsr_done_i(lsr_done), .lsr_result_i(lsr_result),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_err_o(res_err), .busy_o(busy)
  );

  // model: phase, samples held, cycles since the engine was started, window as a queue
  int            m_phase;
  int            m_filled;
  int            m_age;
  logic [DW-1:0] m_win[$];
  logic [15:0]   m_shift;
  logic [RW-1:0] m_res;
  logic          m_err;
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DS*DW-1:0] model_window();
    logic [DS*DW-1:0] r;
    r = '0;
    for (int i = 0; i < DS; i++) r[i*DW +: DW] = m_win[i];
    return r;
  endfunction

  function automatic logic [DS*DW-1:0] seq_window(input int first);
    logic [DS*DW-1:0] r;
    r = '0;
    for (int i = 0; i < DS; i++) r[i*DW +: DW] = DW'(first + i);
    return r;
  endfunction

  task automatic model_reset();
    m_phase  = PH_FILL;
    m_filled = 0;
    m_age    = 0;
    m_win.delete();
    for (int i = 0; i < DS; i++) m_win.push_back('0);
    m_shift = '0;
    m_res   = '0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    logic [DW-1:0] last;
    if (!rst_n) return;
    if (flush) begin
      m_phase  = PH_FILL;
      m_filled = 0;
      return;
    end
    case (m_phase)
      PH_FILL: if (s_valid) begin
        m_win[m_filled] = s_data;
        m_filled++;
        if (m_filled == DS) begin
          m_shift = cfg_shift;
          m_age   = 0;
          m_phase = PH_RUN;
        end
      end
      PH_RUN: begin
        m_age++;
        if (lsr_done) begin
          m_res = lsr_result; m_err = 1'b0; m_phase = PH_RES;
        end else if (m_age == TO) begin
          m_res = '0; m_err = 1'b1; m_phase = PH_RES;
        end
      end
      default: if (res_ready) begin
        if (cfg_slide) begin
          last = m_win[DS-1];
          m_win.delete(0);
          m_win.push_back(last);
          m_filled = DS - 1;
        end else begin
          m_filled = 0;
        end
        m_phase = PH_FILL;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("s_ready",   128'(s_ready),   128'(m_phase == PH_FILL));
      chk("busy",      128'(busy),      128'(m_phase != PH_FILL));
      chk("lsr_start", 128'(lsr_start), 128'(m_phase == PH_RUN));
      chk("res_valid", 128'(res_valid), 128'(m_phase == PH_RES));
      chk("lsr_shift", 128'(lsr_shift), 128'(m_shift));
      chk("lsr_data",  128'(lsr_data),  128'(model_window()));
      chk("res_data",  128'(res_data),  128'(m_res));
      chk("res_err",   128'(res_err),   128'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input int v);
    s_valid = 1'b1;
    s_data  = DW'(v);
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    int  n;
    bool_dummy: begin end
    model_reset();
    repeat (3) tick();
    chk("rst_s_ready",   128'(s_ready),   128'(1));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_lsr_start", 128'(lsr_start), 128'(0));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_lsr_data",  128'(lsr_data),  128'(0));
    rst_n = 1'b1;

    // stream 1..7 with shift 3, engine answers after 5 cycles
    cfg_shift = 16'd3;
    for (int v = 1; v <= DS; v++) send(v);
    chk("t1_start",  128'(lsr_start), 128'(1));
    chk("t1_window", 128'(lsr_data),  128'(seq_window(1)));
    chk("t1_shift",  128'(lsr_shift), 128'(16'd3));
    cfg_shift = 16'd9;
    repeat (4) tick();
    lsr_done = 1'b1; lsr_result = 32'h12345678;
    tick();
    lsr_done = 1'b0;
    chk("t1_res_valid", 128'(res_valid), 128'(1));
    chk("t1_res_data",  128'(res_data),  128'(32'h12345678));
    chk("t1_res_err",   128'(res_err),   128'(0));
    chk("t1_start_off", 128'(lsr_start), 128'(0));

    // sliding accept, one new sample restarts the engine
    res_ready = 1'b1; cfg_slide = 1'b1;
    tick();
    res_ready = 1'b0; cfg_slide = 1'b0;
    chk("t2_s_ready", 128'(s_ready), 128'(1));
    send(8);
    chk("t2_start",  128'(lsr_start), 128'(1));
    chk("t2_window", 128'(lsr_data),  128'(seq_window(2)));
    lsr_done = 1'b1; lsr_result = 32'h000000A5;
    tick();
    lsr_done = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    for (int v = 11; v <= 16; v++) send(v);
    chk("t2_block_wait", 128'(lsr_start), 128'(0));
    send(17);
    chk("t2_block_start", 128'(lsr_start), 128'(1));
    chk("t2_block_window", 128'(lsr_data), 128'(seq_window(11)));

    // timeout with no done
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t3_timeout_cycles", 128'(n), 128'(TO));
    chk("t3_res_err",  128'(res_err),  128'(1));
    chk("t3_res_data", 128'(res_data), 128'(0));
    lsr_done = 1'b1; lsr_result = 32'h0000DEAD;
    tick();
    lsr_done = 1'b0;
    chk("t3_late_done", 128'(res_data), 128'(0));

    // backpressure on the result
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      tick();
      chk("t4_res_data", 128'(res_data),  128'(0));
      chk("t4_s_ready",  128'(s_ready),   128'(0));
      chk("t4_res_valid", 128'(res_valid), 128'(1));
    end
    s_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // flush mid-fill, then flush mid-run
    for (int v = 101; v <= 104; v++) send(v);
    flush = 1'b1; s_valid = 1'b1; s_data = 16'd999;
    tick();
    flush = 1'b0; s_valid = 1'b0;
    for (int v = 200; v <= 205; v++) send(v);
    chk("t5_wait", 128'(lsr_start), 128'(0));
    send(206);
    chk("t5_start",  128'(lsr_start), 128'(1));
    chk("t5_window", 128'(lsr_data),  128'(seq_window(200)));
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_start", 128'(lsr_start), 128'(0));
    chk("t5_flush_ready", 128'(s_ready),   128'(1));
    n = 0;
    repeat (20) begin
      tick();
      if (res_valid) n++;
    end
    chk("t5_no_result", 128'(n), 128'(0));

    // async reset between edges while running
    for (int v = 1; v <= DS; v++) send(v);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_start", 128'(lsr_start), 128'(0));
    chk("t6_rst_busy",  128'(busy),      128'(0));
    chk("t6_rst_ready", 128'(s_ready),   128'(1));
    chk("t6_rst_shift", 128'(lsr_shift), 128'(0));
    tick();
    rst_n = 1'b1;

    // done coincident with timeout
    for (int v = 21; v <= 27; v++) send(v);
    repeat (TO - 1) tick();
    lsr_done = 1'b1; lsr_result = 32'hCAFEF00D;
    tick();
    lsr_done = 1'b0;
    chk("t6_tie_valid", 128'(res_valid), 128'(1));
    chk("t6_tie_err",   128'(res_err),   128'(0));
    chk("t6_tie_data",  128'(res_data),  128'(32'hCAFEF00D));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s_valid    = 1'($urandom_range(0, 1));
      s_data     = 16'($urandom);
      cfg_shift  = 16'($urandom);
      cfg_slide  = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 63) == 0);
      lsr_done   = ($urandom_range(0, 9) == 0);
      lsr_result = $urandom;
      res_ready  = ($urandom_range(0, 2) != 0);
      tick();
    end
    s_valid = 1'b0; flush = 1'b0; lsr_done = 1'b0; res_ready = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
